// File: rtl/pcs_pkg.sv
// Shared PCS constants: sync headers, block width, gearbox sequence range and phase decode.
package pcs_pkg;

  localparam int         GBX_SEQ_MAX = 32;
  localparam int         BLK_W       = 66;
  localparam logic [1:0] SYNC_DATA   = 2'b01;
  localparam logic [1:0] SYNC_CTRL   = 2'b10;
  localparam logic [1:0] SYNC_BAD    = 2'b00;

  typedef enum logic [1:0] {
    PH_LO    = 2'd0,
    PH_HI    = 2'd1,
    PH_PAUSE = 2'd2
  } gbx_phase_e;

  // Even slots carry the low half of a new block, odd slots the high half, slot 32 is the pause.
  function automatic gbx_phase_e phase_of(input logic [5:0] s);
    if (s == 6'(GBX_SEQ_MAX)) return PH_PAUSE;
    else if (s[0])            return PH_HI;
    else                      return PH_LO;
  endfunction

endpackage

// File: rtl/pcs_sync_fifo.sv
// Single-clock block FIFO with registered occupancy and look-ahead occupancy for ready generation.
module pcs_sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     occ_o,
  output logic [$clog2(DEPTH):0]     occ_next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (occ_o == (AW+1)'(DEPTH));
  assign empty = (occ_o == '0);
  assign rd_ok = rd_en_i & ~empty;
  // A read in the same cycle frees a slot, so a write at full is still taken.
  assign wr_ok = wr_en_i & (~full | rd_ok);

  assign rd_data_o = mem[rd_ptr];

  always_comb begin
    occ_next_o = occ_o;
    if (wr_ok & ~rd_ok)      occ_next_o = occ_o + (AW+1)'(1);
    else if (~wr_ok & rd_ok) occ_next_o = occ_o - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_o  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      occ_o <= occ_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= wr_data_i;
  end

endmodule

// File: rtl/tx_gearbox_feed.sv
// Feeds 66b blocks to the GT 64B/66B sync gearbox as 32b halves with txsequence and pause slot.
// Optional TX_GBX_STATS_EN adds popped-block and underflow-event counters.
module tx_gearbox_feed
  import pcs_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AFULL_LVL  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [BLK_W-1:0]  data_i,
  input  logic              data_vld_i,
  output logic              data_rdy_o,
  output logic [31:0]       gt_txdata_o,
  output logic [5:0]        gt_txheader_o,
  output logic [6:0]        gt_txsequence_o,
  output logic              underflow_o,
  input  logic              underflow_clr_i
`ifdef TX_GBX_STATS_EN
  ,
  output logic [31:0]       blk_cnt_o,
  output logic [15:0]       udf_cnt_o
`endif
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] RDY_LVL = (AW+1)'(FIFO_DEPTH - AFULL_LVL);

  logic [BLK_W-1:0] head;
  logic [AW:0]      occ;
  logic [AW:0]      occ_nxt;
  logic [5:0]       seq;
  gbx_phase_e       phase;
  logic             fifo_empty;
  logic             wr_en;
  logic             pop;
  logic             udf_evt;
  logic [1:0]       hdr_p1;
  logic [31:0]      hi_half_p1;

  assign wr_en      = data_vld_i & data_rdy_o;
  assign phase      = phase_of(seq);
  assign fifo_empty = (occ == '0);
  assign pop        = (phase == PH_LO) & ~fifo_empty;
  assign udf_evt    = (phase == PH_LO) & fifo_empty;

  assign gt_txheader_o = {4'b0000, hdr_p1};

  pcs_sync_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (wr_en),
    .wr_data_i  (data_i),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .occ_o      (occ),
    .occ_next_o (occ_nxt)
  );

  // ---- p0 -> p1: sequencer, half-select and status registers ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seq             <= '0;
      gt_txsequence_o <= '0;
      gt_txdata_o     <= '0;
      hdr_p1          <= SYNC_BAD;
      data_rdy_o      <= 1'b0;
      underflow_o     <= 1'b0;
    end else begin
      seq             <= (seq == 6'(GBX_SEQ_MAX)) ? 6'd0 : seq + 6'd1;
      gt_txsequence_o <= {1'b0, seq};
      data_rdy_o      <= (occ_nxt < RDY_LVL);
      underflow_o     <= underflow_clr_i ? 1'b0 : (underflow_o | udf_evt);
      case (phase)
        PH_LO: begin
          // An empty slot still goes out, with a bad header so the far end flags it.
          gt_txdata_o <= pop ? head[33:2] : 32'd0;
          hdr_p1      <= pop ? head[1:0]  : SYNC_BAD;
        end
        PH_HI:   gt_txdata_o <= hi_half_p1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (phase == PH_LO) hi_half_p1 <= pop ? head[65:34] : 32'd0;
  end

`ifdef TX_GBX_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      blk_cnt_o <= '0;
      udf_cnt_o <= '0;
    end else if (underflow_clr_i) begin
      blk_cnt_o <= '0;
      udf_cnt_o <= '0;
    end else begin
      if (pop)     blk_cnt_o <= blk_cnt_o + 32'd1;
      if (udf_evt) udf_cnt_o <= udf_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_gearbox_feed.sv
// Scoreboard bench for tx_gearbox_feed: accepted blocks are queued, a monitor checks every output slot.
module tb_tx_gearbox_feed;
  import pcs_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BLK_W-1:0]  data;
  logic              data_vld;
  logic              data_rdy;
  logic [31:0]       txdata;
  logic [5:0]        txhdr;
  logic [6:0]        txseq;
  logic              underflow;
  logic              underflow_clr;
`ifdef TX_GBX_STATS_EN
  logic [31:0]       blk_cnt;
  logic [15:0]       udf_cnt;
`endif

  always #5 clk = ~clk;

  tx_gearbox_feed #(.FIFO_DEPTH(4), .AFULL_LVL(2)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .data_i          (data),
    .data_vld_i      (data_vld),
    .data_rdy_o      (data_rdy),
    .gt_txdata_o     (txdata),
    .gt_txheader_o   (txhdr),
    .gt_txsequence_o (txseq),
    .underflow_o     (underflow),
    .underflow_clr_i (underflow_clr)
`ifdef TX_GBX_STATS_EN
    ,
    .blk_cnt_o       (blk_cnt),
    .udf_cnt_o       (udf_cnt)
`endif
  );

  typedef struct packed {
    logic [65:0] blk;
    logic [31:0] wcyc;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pcnt = 0;
  int   acc_cnt = 0;
  logic clr_s = 1'b0;

  int          mseq = 0;
  logic [31:0] mdata = '0;
  logic [1:0]  mhdr = '0;
  logic [31:0] mhi = '0;
  logic        mudf = 1'b0;
  int          m_blk = 0;
  int          m_udf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [65:0] mk_blk(input int k);
    logic [31:0] kk;
    logic [63:0] p;
    kk = 32'(k);
    p  = 64'h0123_4567_89AB_CDEF ^ {kk, kk};
    return {p, (kk[0] ? SYNC_CTRL : SYNC_DATA)};
  endfunction

  // Capture what the DUT will see at the coming rising edge, just before it.
  always @(negedge clk) begin
    #4;
    cyc++;
    if (!rst_n) pcnt = 0;
    else        pcnt++;
    clr_s = underflow_clr;
    if (rst_n && data_vld && data_rdy) begin
      q.push_back({data, 32'(cyc)});
      acc_cnt++;
    end
  end

  // Monitor: one expected output per slot after each rising edge.
  always @(negedge clk) begin
    logic [65:0] b;
    logic        set;
    if (!rst_n) begin
      chk("rst_data", 64'(txdata), 64'd0);
      chk("rst_hdr",  64'(txhdr),  64'd0);
      chk("rst_seq",  64'(txseq),  64'd0);
      chk("rst_rdy",  64'(data_rdy), 64'd0);
      chk("rst_udf",  64'(underflow), 64'd0);
      q.delete();
      mseq = 0; mdata = '0; mhdr = '0; mhi = '0; mudf = 1'b0; m_blk = 0; m_udf = 0;
    end else if (pcnt > 0) begin
      set = 1'b0;
      chk("seq", 64'(txseq), 64'(mseq));
      if (mseq != GBX_SEQ_MAX && mseq % 2 == 0) begin
        if (q.size() > 0 && int'(q[0].wcyc) <= cyc - 1) begin
          b = q[0].blk;
          void'(q.pop_front());
          mdata = b[33:2]; mhdr = b[1:0]; mhi = b[65:34];
          m_blk = clr_s ? 0 : m_blk + 1;
        end else begin
          mdata = '0; mhdr = SYNC_BAD; mhi = '0; set = 1'b1;
          m_udf = clr_s ? 0 : m_udf + 1;
        end
        if (clr_s && !set) m_udf = 0;
        if (clr_s && set)  m_blk = 0;
      end else begin
        if (mseq != GBX_SEQ_MAX) mdata = mhi;
        if (clr_s) begin m_blk = 0; m_udf = 0; end
      end
      mudf = clr_s ? 1'b0 : (mudf | set);
      chk("data", 64'(txdata), 64'(mdata));
      chk("hdr",  64'(txhdr),  64'({4'b0000, mhdr}));
      chk("udf",  64'(underflow), 64'(mudf));
      if (pcnt == 1) chk("rdy_after_rst", 64'(data_rdy), 64'd1);
      mseq = (mseq == GBX_SEQ_MAX) ? 0 : mseq + 1;
    end
  end

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data     = mk_blk(acc_cnt);
      data_vld = 1'b1;
    end
  endtask

  initial begin
    int seen;
    int a0;
    int found;
    rst_n = 1'b0; data = '0; data_vld = 1'b0; underflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle: sequence runs with bad headers and a sticky underflow.
    repeat (40) @(negedge clk);
    chk("t1_udf_sticky", 64'(underflow), 64'd1);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;

    // Stream: first data block shows low half then high half.
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (seen == 1) begin
        chk("t2_hi_half", 64'(txdata), 64'h0123_4567);
        seen = 2;
      end else if (txhdr == 6'h01) begin
        chk("t2_lo_half", 64'(txdata), 64'h89AB_CDEF);
        seen = 1;
      end
      data     = mk_blk(acc_cnt);
      data_vld = 1'b1;
    end
    if (seen < 2) chk("t2_timeout", 64'(seen), 64'd2);

    stream(40);
    @(negedge clk);
    underflow_clr = 1'b1;
    data = mk_blk(acc_cnt);
    @(negedge clk);
    underflow_clr = 1'b0;
    data = mk_blk(acc_cnt);
    a0 = acc_cnt;
    stream(66);
    chk("t3_accept_per_66", 64'(acc_cnt - a0), 64'd32);
    chk("t3_no_udf", 64'(underflow), 64'd0);

    // Drain, then clear in the same cycle an empty slot at seq 10 sets the flag.
    data_vld = 1'b0;
    repeat (10) @(negedge clk);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (txseq == 7'd9) found = 1;
    end
    chk("t4_found_seq9", 64'(found), 64'd1);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    chk("t4_seq10", 64'(txseq), 64'd10);
    chk("t4_clr_wins", 64'(underflow), 64'd0);
    chk("t4_hdr_bad", 64'(txhdr), 64'd0);
    chk("t4_data_zero", 64'(txdata), 64'd0);
    @(negedge clk);
    chk("t4_seq11_udf", 64'(underflow), 64'd0);
    @(negedge clk);
    chk("t4_seq12_udf", 64'(underflow), 64'd1);

    // Reset in the middle of a block.
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      @(negedge clk);
      data     = mk_blk(acc_cnt);
      data_vld = 1'b1;
      if (txseq == 7'd15) found = 1;
    end
    chk("t5_found_seq15", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_data", 64'(txdata), 64'd0);
    chk("t5_async_hdr",  64'(txhdr),  64'd0);
    chk("t5_async_seq",  64'(txseq),  64'd0);
    chk("t5_async_rdy",  64'(data_rdy), 64'd0);
    data_vld = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_seq_restart", 64'(txseq), 64'd0);
    stream(120);
    data_vld = 1'b0;
    repeat (5) @(negedge clk);
    #1;
`ifdef TX_GBX_STATS_EN
    chk("t6_blk_cnt", 64'(blk_cnt), 64'(m_blk));
    chk("t6_udf_cnt", 64'(udf_cnt), 64'(m_udf));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
